// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
//   Round-robin arbiter that serialises JK-style updates from NREQ requesters
//   into a shared bank of NBITS state bits. One request is granted and applied
//   per clock; every applied update is reported on registered status outputs.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        per-requester request (level, held until granted)
//   idx        packed bit indices, requester i uses idx[i*IDXW +: IDXW]
//   j, k       per-requester J/K command
//   freeze     blocks all grants; bank, pointer and counter hold
//   gnt        one-hot combinational grant (transfer when req[i] & gnt[i])
//   q_bank     registered bank contents
//   upd_valid  one-cycle pulse after each transfer
//   upd_src    id of the last granted requester
//   upd_idx    index of the last transfer
//   upd_q      new value of the updated bit (0 for out-of-range)
//   err_oor    one-cycle pulse after a transfer with idx >= NBITS
//   upd_cnt    count of applied in-range transfers, wraps at 16 bits
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  localparam int IDXW = (NBITS > 1) ? $clog2(NBITS) : 1,
  localparam int SW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic [NREQ-1:0]      j,
  input  logic [NREQ-1:0]      k,
  input  logic                 freeze,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     q_bank,
  output logic                 upd_valid,
  output logic [SW-1:0]        upd_src,
  output logic [IDXW-1:0]      upd_idx,
  output logic                 upd_q,
  output logic                 err_oor,
  output logic [15:0]          upd_cnt
);

  logic [NBITS-1:0] r_bank;
  logic [SW-1:0]    r_ptr;
  logic             r_valid;
  logic [SW-1:0]    r_src;
  logic [IDXW-1:0]  r_idx;
  logic             r_q;
  logic             r_err;
  logic [15:0]      r_cnt;

  logic [NREQ-1:0]  w_gnt;
  logic [SW-1:0]    w_win;
  logic [SW-1:0]    w_cand;
  logic             w_xfer;
  logic [IDXW-1:0]  w_idx;
  logic             w_inr;
  logic             w_qn;
  logic             w_d;
  logic [NBITS-1:0] w_bank_nxt;

  // Rotating priority search starting at r_ptr; first requesting slot wins.
  always_comb begin
    w_gnt  = '0;
    w_win  = '0;
    w_cand = '0;
    w_xfer = 1'b0;
    if (!reset && !freeze) begin
      for (int unsigned o = 0; o < NREQ; o++) begin
        w_cand = SW'((32'(r_ptr) + o) % 32'(NREQ));
        if (!w_xfer && req[w_cand]) begin
          w_xfer = 1'b1;
          w_win  = w_cand;
        end
      end
    end
    if (w_xfer) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  assign gnt = w_gnt;

  always_comb begin
    w_idx      = idx[32'(w_win)*IDXW +: IDXW];
    w_inr      = (32'(w_idx) < 32'(NBITS));
    w_qn       = w_inr ? r_bank[w_idx] : 1'b0;
    w_d        = (j[w_win] & ~w_qn) | (~k[w_win] & w_qn);
    w_bank_nxt = r_bank;
    if (w_xfer && w_inr) begin
      w_bank_nxt[w_idx] = w_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank  <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
      r_idx   <= '0;
      r_q     <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_bank  <= w_bank_nxt;
      r_valid <= w_xfer;
      r_err   <= w_xfer & ~w_inr;
      if (w_xfer) begin
        r_ptr <= (w_win == SW'(NREQ-1)) ? '0 : w_win + 1'b1;
        r_src <= w_win;
        r_idx <= w_idx;
        r_q   <= w_inr ? w_d : 1'b0;
        if (w_inr) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign q_bank    = r_bank;
  assign upd_valid = r_valid;
  assign upd_src   = r_src;
  assign upd_idx   = r_idx;
  assign upd_q     = r_q;
  assign err_oor   = r_err;
  assign upd_cnt   = r_cnt;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int IDXW  = 3;
  localparam int SW    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              freeze = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   j = '0;
  logic [NREQ-1:0]   k = '0;
  logic [NREQ*IDXW-1:0] idx = '0;
  logic [NREQ-1:0]   gnt;
  logic [NBITS-1:0]  q_bank;
  logic              upd_valid;
  logic [SW-1:0]     upd_src;
  logic [IDXW-1:0]   upd_idx;
  logic              upd_q;
  logic              err_oor;
  logic [15:0]       upd_cnt;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk(clk), .reset(reset), .req(req), .idx(idx), .j(j), .k(k),
    .freeze(freeze), .gnt(gnt), .q_bank(q_bank), .upd_valid(upd_valid),
    .upd_src(upd_src), .upd_idx(upd_idx), .upd_q(upd_q), .err_oor(err_oor),
    .upd_cnt(upd_cnt)
  );

  typedef struct {
    logic             v;
    logic             err;
    logic [SW-1:0]    src;
    logic [IDXW-1:0]  idx;
    logic             q;
    logic [NBITS-1:0] bank;
    logic [15:0]      cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NBITS-1:0] m_bank = '0;
  int               m_ptr  = 0;
  logic [15:0]      m_cnt  = '0;
  logic [SW-1:0]    m_src  = '0;
  logic [IDXW-1:0]  m_idx  = '0;
  logic             m_q    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check the combinational grant, advance the
  // model and queue what the registered outputs must show after the edge.
  task automatic step(input logic rst, input logic frz, input logic [3:0] rq,
                      input logic [3:0] jj, input logic [3:0] kk,
                      input int i0, input int i1, input int i2, input int i3);
    int          ti[4];
    int          w;
    int          c;
    int          n;
    logic [3:0]  eg;
    logic        qn;
    logic        d;
    exp_t        e;
    @(negedge clk);
    ti = '{i0, i1, i2, i3};
    reset  = rst;
    freeze = frz;
    req    = rq;
    j      = jj;
    k      = kk;
    idx    = {3'(i3), 3'(i2), 3'(i1), 3'(i0)};
    #1;
    w = -1;
    if (!rst && !frz) begin
      for (int o = 0; o < NREQ; o++) begin
        c = (m_ptr + o) % NREQ;
        if (w < 0 && rq[c]) w = c;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));

    e.v = 1'b0;
    e.err = 1'b0;
    if (rst) begin
      m_bank = '0; m_ptr = 0; m_cnt = '0; m_src = '0; m_idx = '0; m_q = 1'b0;
    end else if (w >= 0) begin
      n = ti[w];
      e.v = 1'b1;
      m_src = SW'(w);
      m_idx = IDXW'(n);
      m_ptr = (w + 1) % NREQ;
      if (n < NBITS) begin
        qn = m_bank[n];
        case ({jj[w], kk[w]})
          2'b00:   d = qn;
          2'b01:   d = 1'b0;
          2'b10:   d = 1'b1;
          default: d = ~qn;
        endcase
        m_bank[n] = d;
        m_q = d;
        m_cnt = m_cnt + 16'd1;
      end else begin
        e.err = 1'b1;
        m_q = 1'b0;
      end
    end
    e.src  = m_src;
    e.idx  = m_idx;
    e.q    = m_q;
    e.bank = m_bank;
    e.cnt  = m_cnt;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
  endtask

  // Monitor: compares registered outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("upd_valid", 32'(upd_valid), 32'(e.v));
        chk("err_oor",   32'(err_oor),   32'(e.err));
        chk("q_bank",    32'(q_bank),    32'(e.bank));
        chk("upd_cnt",   32'(upd_cnt),   32'(e.cnt));
        chk("upd_src",   32'(upd_src),   32'(e.src));
        chk("upd_idx",   32'(upd_idx),   32'(e.idx));
        chk("upd_q",     32'(upd_q),     32'(e.q));
      end
    end
  end

  initial begin
    logic [3:0] rq;
    // Reset with all requesters active: no grants.
    step(1, 0, 4'b1111, 4'b1111, 4'b1111, 0, 1, 2, 3);
    step(1, 0, 4'b1111, 4'b1111, 4'b1111, 0, 1, 2, 3);
    // First post-reset grant goes to requester 0 (JK=00 hold still counts).
    step(0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 2, 3);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);

    // Requester 1, idx 3: set, toggle, toggle, clear.
    step(0, 0, 4'b0010, 4'b0010, 4'b0000, 0, 3, 0, 0);
    step(0, 0, 4'b0010, 4'b0010, 4'b0010, 0, 3, 0, 0);
    step(0, 0, 4'b0010, 4'b0010, 4'b0010, 0, 3, 0, 0);
    step(0, 0, 4'b0010, 4'b0000, 4'b0010, 0, 3, 0, 0);
    idle(2);

    // Round robin, all toggling their own bit.
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 4'b1111, 4'b1111, 4'b1111, 0, 1, 2, 3);
    idle(1);

    // Contention on bit 5: requester 0 sets, requester 2 clears.
    step(0, 0, 4'b0101, 4'b0001, 4'b0100, 5, 0, 5, 0);
    step(0, 0, 4'b0100, 4'b0001, 4'b0100, 5, 0, 5, 0);
    idle(2);

    // Freeze with a pending out-of-range request, then release.
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0001, 4'b0001, 4'b0000, 7, 0, 0, 0);
    step(0, 0, 4'b0001, 4'b0001, 4'b0000, 7, 0, 0, 0);
    step(0, 0, 4'b1110, 4'b1110, 4'b0000, 0, 6, 2, 4);
    idle(2);

    // Randomized traffic including freeze, reset and out-of-range indices.
    for (int i = 0; i < 3000; i++) begin
      rq = 4'($urandom);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), rq,
           4'($urandom), 4'($urandom),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
    idle(1);

    // Counter wrap: bring the count to 65535, then one more transfer.
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    while (m_cnt != 16'hFFFF) step(0, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 0);
    step(0, 0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0);
    idle(2);

    @(posedge clk);
    #3;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared bank of NBITS JK-behaviour state bits. Each bit is stored in a D-style register.
- NREQ requesters each present a bit index plus a J/K command. One request is granted and applied per clock.
- Sits between control agents and a shared flag/status register bank. It serialises concurrent JK updates and reports each applied update.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBITS, 8, number of JK state bits in the bank (2..32).
- IDXW, derived as clog2(NBITS) (minimum 1), index width per requester. Not user-overridable.
- SW, derived as clog2(NREQ), source-id width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; level, held until granted.
- idx  input  NREQ*IDXW  packed bit index; requester i uses idx[i*IDXW +: IDXW].
- j  input  NREQ  J command per requester.
- k  input  NREQ  K command per requester.
- freeze  input  1  when high, no grants are issued and the bank holds its value.
- gnt  output  NREQ  one-hot combinational grant; a transfer occurs on a clk edge where req[i]&gnt[i].
- q_bank  output  NBITS  registered bank contents.
- upd_valid  output  1  registered; pulses 1 cycle after each transfer.
- upd_src  output  SW  registered id of the last granted requester.
- upd_idx  output  IDXW  registered index of the last transfer.
- upd_q  output  1  registered new value of the updated bit.
- err_oor  output  1  registered; pulses 1 cycle after a transfer whose idx >= NBITS.
- upd_cnt  output  16  registered count of applied in-range transfers; wraps at 65535->0.

Behaviour:
- Reset (clk edge with reset=1): q_bank=0, upd_valid=0, upd_src=0, upd_idx=0, upd_q=0, err_oor=0, upd_cnt=0, rr pointer=0. reset has priority over every other input in that cycle.
- While reset=1, gnt=0.
- Arbitration (combinational):
  - If freeze=0 and req!=0, gnt is one-hot for the first requester with req=1, searching i=ptr, ptr+1, ... mod NREQ.
  - Otherwise gnt=0.
  - gnt never asserts for a requester whose req=0.
- Pointer update: after a transfer from requester w, ptr <= (w+1) mod NREQ. With no transfer, ptr holds.
- Bank update on a transfer from w with index n=idx_w, Qn the current bit value:
  - Next value is D = (J & ~Qn) | (~K & Qn).
  - 00 hold, 01 clear, 10 set, 11 toggle.
  - Only bit n changes. All other bits hold.
- Out-of-range (n >= NBITS):
  - Transfer still completes: grant consumed, pointer advances.
  - Bank unchanged, upd_cnt unchanged.
  - Next cycle: err_oor=1, upd_valid=1, upd_q=0.
- Status: upd_valid, upd_src, upd_idx and upd_q are written in the same cycle as the transfer, so they are visible the next cycle. upd_valid=0 in any cycle following a non-transfer cycle. upd_src, upd_idx and upd_q hold their last values.
- Latency: the new bit value appears on q_bank exactly 1 clock after the transfer edge.
- upd_cnt increments by 1 per in-range transfer, including JK=00 holds.
- Fairness: with all requesters continuously requesting, each is granted exactly once every NREQ cycles.
- Freeze: bank, ptr and counter hold. upd_valid=0 the following cycle. Pending reqs stay pending.
- Reset mid-stream: any request presented in the reset cycle is not applied. Arbitration restarts at ptr=0.
- No combinational path from any output register to gnt other than through ptr.

Test Plan:
- Reset: drive reset=1 for 2 cycles with req=4'b1111 -> gnt=0, q_bank=8'h00, upd_cnt=0. First post-reset grant goes to requester 0.
- Single JK ops on requester 1, idx=3: 10 set, then 11 toggle, then 11, then 01 -> q_bank[3] = 1,0,1,0 one cycle after each transfer. upd_src=1, upd_idx=3, upd_cnt=4.
- Round-robin: req=4'b1111 held, each with toggle on its own idx 0..3 -> grants 0,1,2,3,0,... After 4 cycles q_bank=8'h0F. After 8 cycles q_bank=8'h00, upd_cnt=8.
- Contention on the same bit: requesters 0 and 2 both target idx 5 (0 sets, 2 clears) -> grant 0 first, q_bank[5]=1. Then grant 2, q_bank[5]=0. Then no activity.
- Freeze and out-of-range: NBITS=6, freeze=1 for 3 cycles with req pending -> gnt=0, q_bank stable. Release with idx=7 -> err_oor pulses 1 cycle, q_bank unchanged, upd_cnt unchanged, ptr advances.
- Counter wrap: preload via 65535 in-range transfers, then one more -> upd_cnt=0.
